// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between the UART RX/TX pair and the system datapath.
// Parses byte-framed commands (write, read, load-and-operate, operate), drives
// register-file and ALU strobes, and pushes response bytes into the TX FIFO.
// Every output comes straight from a flop.
module uart_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] OpWrite  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OpRead   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OpLoadOp = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OpAluOp  = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpA,
    StOpB,
    StAluFun,
    StAluWait,
    StTxRd,
    StTxLo,
    StTxHi
  } state_e;

  state_e state_q, state_d;

  // Frame context: latched write address and the response being returned.
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;

  // Output registers.
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  clk_en_q, clk_en_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;

  // Next-state, frame context and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    res_d     = res_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    clk_en_d  = 1'b0;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OpWrite:  state_d = StWrAddr;
            OpRead:   state_d = StRdAddr;
            OpLoadOp: state_d = StOpA;
            OpAluOp:  state_d = StAluFun;
            default:  state_d = StIdle;  // unknown opcode is dropped
          endcase
        end
      end

      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = StWrData;
        end
      end

      StWrData: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = StIdle;
        end
      end

      StRdAddr: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = StRdWait;
        end
      end

      StRdWait: begin
        if (RdData_Valid) begin
          res_d   = {{DATA_WIDTH{1'b0}}, RdData};
          state_d = StTxRd;
        end
      end

      // Operand A always lands in register 0.
      StOpA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = '0;
          wr_data_d = RX_P_DATA;
          state_d   = StOpB;
        end
      end

      // Operand B always lands in register 1.
      StOpB: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          state_d   = StAluFun;
        end
      end

      StAluFun: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = StAluWait;
        end
      end

      // Keep the ALU enabled until it reports a result; enables fall the cycle after.
      StAluWait: begin
        if (OUT_VALID) begin
          res_d   = ALU_OUT;
          state_d = StTxLo;
        end else begin
          alu_en_d = 1'b1;
          clk_en_d = 1'b1;
        end
      end

      StTxRd: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = StIdle;
        end
      end

      StTxLo: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_WIDTH-1:0];
          state_d   = StTxHi;
        end
      end

      StTxHi: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State, frame context and output registers; reset drops any partial frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      res_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      address_q <= '0;
      wr_data_q <= '0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      clk_en_q  <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      res_q     <= res_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      clk_en_q  <= clk_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = address_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: command vectors from a table, expected
// strobe events queued at drive time and popped as the DUT emits them.
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        FIFO_FULL;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;

  uart_cmd_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .FUN_WIDTH (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .ALU_OUT     (ALU_OUT),
    .OUT_VALID   (OUT_VALID),
    .FIFO_FULL   (FIFO_FULL),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Address     (Address),
    .WrData      (WrData),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .CLK_EN      (CLK_EN),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] EvWr = 2'd0, EvRd = 2'd1, EvAlu = 2'd2, EvTx = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;  // address or ALU function
    logic [7:0] d;  // write data, TX byte, or CLK_EN for ALU events
  } ev_t;

  typedef struct packed {
    logic [2:0]      nb;
    logic [3:0][7:0] b;
    logic [7:0]      rd;
    logic [15:0]     alu;
    logic [7:0]      full;
    logic [2:0]      nev;
    ev_t [4:0]       ev;
  } vec_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   fails = 0;
  logic [7:0]  cur_rd = 8'h00;
  logic [15:0] cur_alu = 16'h0000;
  logic rd_stall = 1'b0;
  logic alu_stall = 1'b0;
  int   inject_req = 0;
  int   inject_ack = 0;
  vec_t vecs[9];

  function automatic vec_t mk(int nb, logic [31:0] bytes, logic [7:0] rd, logic [15:0] alu,
                              logic [7:0] full);
    vec_t v;
    v = '0;
    v.nb = 3'(nb);
    for (int i = 0; i < 4; i++) v.b[i] = bytes[31-8*i -: 8];
    v.rd = rd;
    v.alu = alu;
    v.full = full;
    return v;
  endfunction

  function automatic vec_t add(vec_t v, logic [1:0] k, logic [7:0] a, logic [7:0] d);
    vec_t r;
    r = v;
    r.ev[r.nev] = '{kind: k, a: a, d: d};
    r.nev = r.nev + 3'd1;
    return r;
  endfunction

  task automatic check_ev(logic [1:0] k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h, expected no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        fails++;
        $display("FAIL event: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Watches DUT strobes at the falling edge and scores them against the queue.
  task automatic monitor();
    logic alu_prev = 1'b0;
    logic full_prev = 1'b0;
    logic ov_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (WrEn) check_ev(EvWr, {4'b0, Address}, WrData);
        if (RdEn) check_ev(EvRd, {4'b0, Address}, 8'h00);
        if (ALU_EN && !alu_prev) check_ev(EvAlu, {4'b0, ALU_FUN}, {7'b0, CLK_EN});
        if (TX_D_VLD) begin
          check_ev(EvTx, 8'h00, TX_P_DATA);
          checks++;
          if (full_prev) begin
            fails++;
            $display("FAIL tx_while_full: got TX_D_VLD=1 with FIFO full, expected 0");
          end
        end
        if (ov_prev && alu_prev) begin
          checks++;
          if (ALU_EN || CLK_EN) begin
            fails++;
            $display("FAIL alu_en_drop: got ALU_EN=%0b CLK_EN=%0b, expected 0 0", ALU_EN, CLK_EN);
          end
        end
      end
      alu_prev  = ALU_EN;
      full_prev = FIFO_FULL;
      ov_prev   = OUT_VALID;
    end
  endtask

  // Register file model: answers each read strobe two cycles later.
  task automatic rd_resp();
    forever begin
      @(negedge CLK);
      if (RdEn && !RST) begin
        while (rd_stall) @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1 RdData = cur_rd; RdData_Valid = 1'b1;
        @(posedge CLK);
        #1 RdData_Valid = 1'b0;
      end
    end
  endtask

  // ALU model: reports a result three cycles after enable; can also inject stray pulses.
  task automatic alu_resp();
    forever begin
      @(negedge CLK);
      if (inject_req != inject_ack) begin
        @(posedge CLK);
        #1 ALU_OUT = 16'hFFFF; OUT_VALID = 1'b1;
        @(posedge CLK);
        #1 OUT_VALID = 1'b0;
        inject_ack = inject_req;
      end else if (ALU_EN && !RST) begin
        while (alu_stall) @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1 ALU_OUT = cur_alu; OUT_VALID = 1'b1;
        @(posedge CLK);
        #1 OUT_VALID = 1'b0;
      end
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    @(posedge CLK);
    #1 RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1 RX_D_VLD = 1'b0; RX_P_DATA = 8'h00;
    repeat (2) @(posedge CLK);
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
      fails++;
      $display("FAIL %s: got WrEn=%b RdEn=%b Addr=%h WrData=%h ALU_EN=%b FUN=%h CLK_EN=%b TX=%h TXV=%b, expected all 0",
               name, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD);
    end
  endtask

  task automatic wait_drain(int idx);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%0d: got %0d events outstanding, expected 0", idx, exp_q.size());
    end
  endtask

  task automatic run_vec(vec_t v, int idx);
    int ntx = 0;
    cur_rd  = v.rd;
    cur_alu = v.alu;
    for (int i = 0; i < int'(v.nev); i++) begin
      exp_q.push_back(v.ev[i]);
      if (v.ev[i].kind == EvTx) ntx++;
    end
    @(posedge CLK);
    #1 FIFO_FULL = (v.full != 8'd0);
    for (int i = 0; i < int'(v.nb); i++) send_byte(v.b[i]);
    if (v.full != 8'd0) begin
      repeat (int'(v.full)) @(posedge CLK);
      checks++;
      if (exp_q.size() != ntx) begin
        fails++;
        $display("FAIL tx_held_%0d: got %0d events pending, expected %0d", idx, exp_q.size(), ntx);
      end
      #1 FIFO_FULL = 1'b0;
    end
    wait_drain(idx);
    repeat (4) @(posedge CLK);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    RdData = 8'h00; RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000; OUT_VALID = 1'b0;
    FIFO_FULL = 1'b0;

    vecs[0] = add(mk(3, 32'hAA053C00, 8'h00, 16'h0000, 8'd0), EvWr, 8'h05, 8'h3C);
    vecs[1] = add(add(mk(2, 32'hBB050000, 8'h3C, 16'h0000, 8'd0), EvRd, 8'h05, 8'h00),
                  EvTx, 8'h00, 8'h3C);
    vecs[2] = add(add(add(add(add(mk(4, 32'hCC070300, 8'h00, 16'h000A, 8'd0),
                  EvWr, 8'h00, 8'h07), EvWr, 8'h01, 8'h03), EvAlu, 8'h00, 8'h01),
                  EvTx, 8'h00, 8'h0A), EvTx, 8'h00, 8'h00);
    vecs[3] = add(add(add(mk(2, 32'hDD020000, 8'h00, 16'h1234, 8'd10),
                  EvAlu, 8'h02, 8'h01), EvTx, 8'h00, 8'h34), EvTx, 8'h00, 8'h12);
    vecs[4] = mk(1, 32'h55000000, 8'h00, 16'h0000, 8'd0);
    vecs[5] = add(mk(3, 32'hAA01FF00, 8'h00, 16'h0000, 8'd0), EvWr, 8'h01, 8'hFF);
    vecs[6] = add(add(mk(2, 32'hBB0F0000, 8'hA5, 16'h0000, 8'd0), EvRd, 8'h0F, 8'h00),
                  EvTx, 8'h00, 8'hA5);
    vecs[7] = add(add(add(mk(2, 32'hDD0F0000, 8'h00, 16'hFFFF, 8'd0),
                  EvAlu, 8'h0F, 8'h01), EvTx, 8'h00, 8'hFF), EvTx, 8'h00, 8'hFF);
    vecs[8] = add(add(add(add(add(mk(4, 32'hCCFF8009, 8'h00, 16'hBEEF, 8'd3),
                  EvWr, 8'h00, 8'hFF), EvWr, 8'h01, 8'h80), EvAlu, 8'h09, 8'h01),
                  EvTx, 8'h00, 8'hEF), EvTx, 8'h00, 8'hBE);

    fork
      monitor();
      rd_resp();
      alu_resp();
    join_none

    repeat (3) @(posedge CLK);
    #1 check_zero("reset_values");
    @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // RX bytes arriving while a read is outstanding must be dropped.
    rd_stall = 1'b1;
    cur_rd = 8'h5A;
    exp_q.push_back('{kind: EvRd, a: 8'h03, d: 8'h00});
    exp_q.push_back('{kind: EvTx, a: 8'h00, d: 8'h5A});
    send_byte(8'hBB);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    rd_stall = 1'b0;
    wait_drain(100);
    repeat (4) @(posedge CLK);

    // A stray OUT_VALID while idle must not produce a response.
    inject_req++;
    repeat (8) @(posedge CLK);
    wait_drain(101);

    // Reset while waiting on the ALU.
    alu_stall = 1'b1;
    exp_q.push_back('{kind: EvAlu, a: 8'h02, d: 8'h01});
    send_byte(8'hDD);
    send_byte(8'h02);
    begin
      int n = 0;
      while (!ALU_EN && n < 50) begin
        @(negedge CLK);
        n++;
      end
    end
    checks++;
    if (!ALU_EN) begin
      fails++;
      $display("FAIL alu_wait_entry: got ALU_EN=0, expected 1");
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_zero("reset_in_alu_wait");
    wait_drain(102);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    run_vec(add(add(mk(2, 32'hBB010000, 8'h77, 16'h0000, 8'd0), EvRd, 8'h01, 8'h00),
                EvTx, 8'h00, 8'h77), 103);
    alu_stall = 1'b0;
    repeat (10) @(posedge CLK);
    wait_drain(104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
